alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  ID->EX boundary of the pipelined RV32I core; the producer side of the ALU interface.
//  Decodes the ID instruction into the 4-bit ALU op code, selects operands A/B, generates immediates.
//  Registers everything into the ID/EX pipeline register under stall/flush control.
//  The EX-stage ALU consumes ex_op_a/ex_op_b/ex_alu_control directly, with no further decode.
// PARAMETERS
//  XLEN        32     datapath width; only 32 is supported
//  RESET_PC    0      value driven on ex_pc while reset is held
// PORTS
//  clk             in   1     rising-edge clock, the only clock
//  rst             in   1     synchronous, active-high reset
//  id_valid        in   1     id_instr holds a real instruction this cycle
//  id_instr        in   32    instruction word from IF/ID
//  id_pc           in   32    PC of id_instr
//  id_rs1_data     in   32    register-file read port 1, already forwarded
//  id_rs2_data     in   32    register-file read port 2, already forwarded
//  stall           in   1     hold the ID/EX register (hazard unit)
//  flush           in   1     insert a bubble into EX (branch redirect)
//  ex_valid        out  1     EX slot holds a real instruction
//  ex_alu_control  out  4     ALU op code, encoding below
//  ex_op_a         out  32    ALU operand A
//  ex_op_b         out  32    ALU operand B
//  ex_rs2_data     out  32    store data, passed through
//  ex_imm          out  32    sign-extended immediate (branch/jump target adder)
//  ex_pc           out  32    PC of EX instruction
//  ex_rd           out  5     destination register
//  ex_reg_write    out  1     rd is written; forced 0 when rd==0
//  ex_mem_read     out  1     LOAD
//  ex_mem_write    out  1     STORE
//  ex_branch       out  1     BRANCH; ex_funct3 selects the condition
//  ex_jump         out  1     JAL or JALR
//  ex_funct3       out  3     funct3 passthrough
//  ex_illegal      out  1     opcode/funct not in the supported RV32I set
// BEHAVIOUR
//  ALU code = {funct3, alt}: ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000,
//   SRL 1010, SRA 1011, OR 1100, AND 1110.
//  - OP (0110011): alt = instr[30] for funct3 000/101 only. A=rs1, B=rs2.
//  - OP-IMM (0010011): alt = instr[30] only for funct3 101; ADDI never yields SUB. A=rs1, B=I-imm.
//    Shifts use B={27'b0, shamt}.
//  - LUI: A=0, B=U-imm, ADD.  AUIPC: A=pc, B=U-imm, ADD.
//  - LOAD/STORE: A=rs1, B=I-imm or S-imm, ADD.
//  - JAL/JALR: A=pc, B=4, ADD (link value). ex_imm=J-imm or I-imm.
//  - BRANCH: A=rs1, B=rs2. BEQ/BNE->SUB, BLT/BGE->SLT, BLTU/BGEU->SLTU. ex_imm=B-imm.
//  - Illegal: bad opcode, bad funct7 on OP, or bad SLLI/SRxI imm[11:5].
//    Outputs ex_illegal=1 with reg_write=mem_read=mem_write=branch=jump=0 and ALU=ADD.
//  - Register update priority, evaluated each rising edge:
//    rst > flush > stall > load.
//    * rst: every output 0 except ex_pc=RESET_PC.
//    * flush: ex_valid=0 and all control flags 0; datapath fields don't-care (held).
//    * stall (no flush): every output holds.
//    * else: load the decode of id_* with ex_valid=id_valid.
//  - flush and stall in the same cycle -> bubble; flush wins.
//  - id_valid=0 on load -> ex_valid=0 and all control flags 0.
//  - Latency: exactly 1 cycle, ID inputs at edge N -> EX outputs after edge N.
//    No combinational path from any input to any output.
//  - Reset asserted mid-stall clears the register; stall is ignored while rst=1.
// STRUCTURE
//  - Package rv_isa_pkg: ALU_* 4-bit localparams (codes above); OPC_* 7-bit opcodes; imm-type enum.
//  - Sub-module rv_imm_gen: combinational instr -> I/S/B/U/J immediates.
//  - Top: decode comb block plus a single always @(posedge clk) register block.
// TESTING
//  1. add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, no stall
//     -> next cycle ex_alu_control=0000, op_a=5, op_b=7, rd=3, reg_write=1.
//  2. sub (0x402081B3)->0001. srai x5,x6,3 (0x40335293)->1011, op_b=3.
//     addi x1,x0,-1 (0xFFF00093)->0000, op_b=0xFFFFFFFF.
//  3. lui x2,0x12345 (0x12345137) -> op_a=0, op_b=0x12345000, ALU 0000.
//     bltu x1,x2 -> ALU 0110, branch=1, reg_write=0.
//  4. Load add, then stall=1 for 3 cycles while id_instr changes -> EX outputs frozen.
//     stall=1 with flush=1 -> ex_valid=0 next cycle.
//  5. rst=1 during stall -> all flags 0, ex_pc=RESET_PC.
//     Opcode 0x7F -> ex_illegal=1, reg_write=0. addi x0,x0,1 -> reg_write=0.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// Shared RV32I ISA definitions for the ID->EX issue slice.
//   - ALU_*  : 4-bit ALU op codes, formed as {funct3, alt}
//   - OPC_*  : 7-bit major opcodes of the supported RV32I subset
//   - imm_type_e : which immediate format an instruction carries
//   - id_ex_t    : contents of the ID/EX pipeline register
package rv_isa_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_OR   = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b1110;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_control;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic [2:0]  funct3;
    logic        illegal;
  } id_ex_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RV32I immediate generator.
//   i_instr  : instruction word
//   o_imm_i/s/b/u/j : sign-extended I/S/B/U/J immediates (B and J are byte offsets)
module rv_imm_gen (
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm_i,
  output logic [31:0] o_imm_s,
  output logic [31:0] o_imm_b,
  output logic [31:0] o_imm_u,
  output logic [31:0] o_imm_j
);

  assign o_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign o_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign o_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                    i_instr[11:8], 1'b0};
  assign o_imm_u = {i_instr[31:12], 12'b0};
  assign o_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                    i_instr[30:21], 1'b0};

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX boundary of the RV32I pipeline: decodes the ID instruction into an
// ALU op code and operands, then registers the result into ID/EX.
//   clk, rst            : clock, synchronous active-high reset
//   id_valid/instr/pc   : instruction in ID and its PC
//   id_rs1/rs2_data     : forwarded register operands
//   stall, flush        : hold the register / insert a bubble (flush wins)
//   ex_*                : registered ID/EX contents consumed by EX
module alu_issue_stage
  import rv_isa_pkg::*;
#(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [3:0]      ex_alu_control,
  output logic [XLEN-1:0] ex_op_a,
  output logic [XLEN-1:0] ex_op_b,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic [2:0]      ex_funct3,
  output logic            ex_illegal
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  logic [3:0]  w_alu;
  logic [31:0] w_op_a, w_op_b, w_imm;
  imm_type_e   w_imm_type;
  logic        w_illegal, w_wb, w_mr, w_mw, w_br, w_jp;
  id_ex_t      w_dec;
  id_ex_t      r_ex;

  assign w_opcode = id_instr[6:0];
  assign w_rd     = id_instr[11:7];
  assign w_funct3 = id_instr[14:12];
  assign w_shamt  = id_instr[24:20];
  assign w_funct7 = id_instr[31:25];

  rv_imm_gen u_imm_gen (
    .i_instr (id_instr),
    .o_imm_i (w_imm_i),
    .o_imm_s (w_imm_s),
    .o_imm_b (w_imm_b),
    .o_imm_u (w_imm_u),
    .o_imm_j (w_imm_j)
  );

  always_comb begin
    w_alu      = ALU_ADD;
    w_op_a     = id_rs1_data;
    w_op_b     = id_rs2_data;
    w_imm_type = IMM_I;
    w_illegal  = 1'b0;
    w_wb       = 1'b0;
    w_mr       = 1'b0;
    w_mw       = 1'b0;
    w_br       = 1'b0;
    w_jp       = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_wb = 1'b1;
        if (w_funct7 == 7'b0000000) begin
          w_alu = {w_funct3, 1'b0};
        end else if (w_funct7 == 7'b0100000 &&
                     (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
          w_alu = {w_funct3, 1'b1};
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        w_wb   = 1'b1;
        w_op_b = w_imm_i;
        case (w_funct3)
          3'b001: begin
            w_op_b    = {27'b0, w_shamt};
            w_alu     = ALU_SLL;
            w_illegal = (w_funct7 != 7'b0000000);
          end
          3'b101: begin
            w_op_b = {27'b0, w_shamt};
            if (w_funct7 == 7'b0000000)      w_alu = ALU_SRL;
            else if (w_funct7 == 7'b0100000) w_alu = ALU_SRA;
            else                             w_illegal = 1'b1;
          end
          // instr[30] is part of the immediate here, so ADDI never becomes SUB
          default: w_alu = {w_funct3, 1'b0};
        endcase
      end
      OPC_LUI: begin
        w_wb       = 1'b1;
        w_op_a     = '0;
        w_op_b     = w_imm_u;
        w_imm_type = IMM_U;
      end
      OPC_AUIPC: begin
        w_wb       = 1'b1;
        w_op_a     = id_pc;
        w_op_b     = w_imm_u;
        w_imm_type = IMM_U;
      end
      OPC_LOAD: begin
        w_wb   = 1'b1;
        w_mr   = 1'b1;
        w_op_b = w_imm_i;
      end
      OPC_STORE: begin
        w_mw       = 1'b1;
        w_op_b     = w_imm_s;
        w_imm_type = IMM_S;
      end
      OPC_JAL: begin
        w_wb       = 1'b1;
        w_jp       = 1'b1;
        w_op_a     = id_pc;
        w_op_b     = 32'd4;
        w_imm_type = IMM_J;
      end
      OPC_JALR: begin
        w_wb   = 1'b1;
        w_jp   = 1'b1;
        w_op_a = id_pc;
        w_op_b = 32'd4;
      end
      OPC_BRANCH: begin
        w_br       = 1'b1;
        w_imm_type = IMM_B;
        if (!w_funct3[2])    w_alu = ALU_SUB;
        else if (w_funct3[1]) w_alu = ALU_SLTU;
        else                 w_alu = ALU_SLT;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_alu = ALU_ADD;
      w_wb  = 1'b0;
      w_mr  = 1'b0;
      w_mw  = 1'b0;
      w_br  = 1'b0;
      w_jp  = 1'b0;
    end
  end

  always_comb begin
    case (w_imm_type)
      IMM_I:   w_imm = w_imm_i;
      IMM_S:   w_imm = w_imm_s;
      IMM_B:   w_imm = w_imm_b;
      IMM_U:   w_imm = w_imm_u;
      IMM_J:   w_imm = w_imm_j;
      default: w_imm = w_imm_i;
    endcase
  end

  // Control flags are qualified by id_valid so a non-instruction never
  // produces side effects downstream.
  always_comb begin
    w_dec             = '0;
    w_dec.valid       = id_valid;
    w_dec.alu_control = w_alu;
    w_dec.op_a        = w_op_a;
    w_dec.op_b        = w_op_b;
    w_dec.rs2_data    = id_rs2_data;
    w_dec.imm         = w_imm;
    w_dec.pc          = id_pc;
    w_dec.rd          = w_rd;
    w_dec.reg_write   = id_valid & w_wb & (w_rd != 5'd0);
    w_dec.mem_read    = id_valid & w_mr;
    w_dec.mem_write   = id_valid & w_mw;
    w_dec.branch      = id_valid & w_br;
    w_dec.jump        = id_valid & w_jp;
    w_dec.funct3      = w_funct3;
    w_dec.illegal     = id_valid & w_illegal;
  end

  // rst > flush > stall > load; a flush keeps the datapath fields as they were.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex    <= '0;
      r_ex.pc <= RESET_PC;
    end else if (flush) begin
      r_ex.valid     <= 1'b0;
      r_ex.reg_write <= 1'b0;
      r_ex.mem_read  <= 1'b0;
      r_ex.mem_write <= 1'b0;
      r_ex.branch    <= 1'b0;
      r_ex.jump      <= 1'b0;
      r_ex.illegal   <= 1'b0;
    end else if (!stall) begin
      r_ex <= w_dec;
    end
  end

  assign ex_valid       = r_ex.valid;
  assign ex_alu_control = r_ex.alu_control;
  assign ex_op_a        = r_ex.op_a;
  assign ex_op_b        = r_ex.op_b;
  assign ex_rs2_data    = r_ex.rs2_data;
  assign ex_imm         = r_ex.imm;
  assign ex_pc          = r_ex.pc;
  assign ex_rd          = r_ex.rd;
  assign ex_reg_write   = r_ex.reg_write;
  assign ex_mem_read    = r_ex.mem_read;
  assign ex_mem_write   = r_ex.mem_write;
  assign ex_branch      = r_ex.branch;
  assign ex_jump        = r_ex.jump;
  assign ex_funct3      = r_ex.funct3;
  assign ex_illegal     = r_ex.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush;
  logic [31:0] id_instr, id_pc, id_rs1_data, id_rs2_data;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_branch, ex_jump, ex_illegal;
  logic [3:0]  ex_alu_control;
  logic [31:0] ex_op_a, ex_op_b, ex_rs2_data, ex_imm, ex_pc;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  alu_issue_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_rs1_data    (id_rs1_data),
    .id_rs2_data    (id_rs2_data),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_alu_control (ex_alu_control),
    .ex_op_a        (ex_op_a),
    .ex_op_b        (ex_op_b),
    .ex_rs2_data    (ex_rs2_data),
    .ex_imm         (ex_imm),
    .ex_pc          (ex_pc),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_branch      (ex_branch),
    .ex_jump        (ex_jump),
    .ex_funct3      (ex_funct3),
    .ex_illegal     (ex_illegal)
  );

  always #5 clk = ~clk;

  // Expected EX-slot contents; care_* mark fields the design leaves undefined.
  typedef struct packed {
    logic        valid;
    logic [3:0]  alu;
    logic [31:0] op_a, op_b, rs2, imm, pc;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, jp;
    logic [2:0]  f3;
    logic        ill;
    logic        care_ops, care_imm;
  } exp_t;

  exp_t exp_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b, input logic v);
    exp_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] immI, immS, immB, immU, immJ;
    logic legal, wb;
    int si;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    si  = $signed(ins);
    immI = 32'(si >>> 20);
    immS = 32'((si >>> 25) * 32 + int'(ins[11:7]));
    immB = 32'((ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
               + int'(ins[11:8]) * 2);
    immU = ins & 32'hFFFF_F000;
    immJ = 32'((ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
               + int'(ins[30:21]) * 2);
    e = '0;
    e.valid = v;
    e.pc = pc;
    e.rs2 = b;
    e.rd = ins[11:7];
    e.f3 = f3;
    e.care_ops = 1'b1;
    e.care_imm = 1'b1;
    legal = 1'b1;
    wb = 1'b0;
    case (opc)
      7'h33: begin
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        e.alu = {f3, f7 == 7'h20};
        e.op_a = a; e.op_b = b; wb = 1'b1; e.care_imm = 1'b0;
      end
      7'h13: begin
        wb = 1'b1; e.op_a = a; e.imm = immI;
        if (f3 == 3'd1) begin
          legal = (f7 == 7'h00); e.op_b = 32'(ins[24:20]); e.alu = 4'b0010;
        end else if (f3 == 3'd5) begin
          legal = (f7 == 7'h00) || (f7 == 7'h20);
          e.op_b = 32'(ins[24:20]); e.alu = (f7 == 7'h20) ? 4'b1011 : 4'b1010;
        end else begin
          e.op_b = immI; e.alu = {f3, 1'b0};
        end
      end
      7'h37: begin wb = 1'b1; e.op_a = 32'd0; e.op_b = immU; e.imm = immU; end
      7'h17: begin wb = 1'b1; e.op_a = pc;    e.op_b = immU; e.imm = immU; end
      7'h03: begin wb = 1'b1; e.mr = 1'b1; e.op_a = a; e.op_b = immI; e.imm = immI; end
      7'h23: begin e.mw = 1'b1; e.op_a = a; e.op_b = immS; e.imm = immS; end
      7'h6F: begin wb = 1'b1; e.jp = 1'b1; e.op_a = pc; e.op_b = 32'd4; e.imm = immJ; end
      7'h67: begin wb = 1'b1; e.jp = 1'b1; e.op_a = pc; e.op_b = 32'd4; e.imm = immI; end
      7'h63: begin
        e.br = 1'b1; e.op_a = a; e.op_b = b; e.imm = immB;
        if (f3 == 3'd0 || f3 == 3'd1)      e.alu = 4'b0001;
        else if (f3 == 3'd4 || f3 == 3'd5) e.alu = 4'b0100;
        else                               e.alu = 4'b0110;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.ill = 1'b1; e.alu = 4'b0000; wb = 1'b0;
      e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.jp = 1'b0;
      e.care_ops = 1'b0; e.care_imm = 1'b0;
    end
    e.rw = wb && (ins[11:7] != 5'd0);
    if (!v) begin
      e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.jp = 1'b0; e.ill = 1'b0;
    end
    return e;
  endfunction

  // Advance one clock, updating the expected register from the inputs
  // presented before the edge.
  task automatic tick();
    exp_t nxt;
    if (rst) begin
      nxt = '0;
      nxt.pc = RST_PC;
      nxt.care_ops = 1'b1;
      nxt.care_imm = 1'b1;
    end else if (flush) begin
      nxt = exp_q;
      nxt.valid = 1'b0;
      nxt.rw = 1'b0; nxt.mr = 1'b0; nxt.mw = 1'b0;
      nxt.br = 1'b0; nxt.jp = 1'b0; nxt.ill = 1'b0;
    end else if (stall) begin
      nxt = exp_q;
    end else begin
      nxt = model(id_instr, id_pc, id_rs1_data, id_rs2_data, id_valid);
    end
    @(posedge clk);
    #1;
    exp_q = nxt;
  endtask

  task automatic check_all();
    check("valid", 32'(ex_valid), 32'(exp_q.valid));
    check("alu", 32'(ex_alu_control), 32'(exp_q.alu));
    if (exp_q.care_ops) begin
      check("op_a", ex_op_a, exp_q.op_a);
      check("op_b", ex_op_b, exp_q.op_b);
    end
    if (exp_q.care_imm) check("imm", ex_imm, exp_q.imm);
    check("rs2", ex_rs2_data, exp_q.rs2);
    check("pc", ex_pc, exp_q.pc);
    check("rd", 32'(ex_rd), 32'(exp_q.rd));
    check("reg_write", 32'(ex_reg_write), 32'(exp_q.rw));
    check("mem_read", 32'(ex_mem_read), 32'(exp_q.mr));
    check("mem_write", 32'(ex_mem_write), 32'(exp_q.mw));
    check("branch", 32'(ex_branch), 32'(exp_q.br));
    check("jump", 32'(ex_jump), 32'(exp_q.jp));
    check("funct3", 32'(ex_funct3), 32'(exp_q.f3));
    check("illegal", 32'(ex_illegal), 32'(exp_q.ill));
  endtask

  task automatic set_id(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b);
    id_valid = 1'b1;
    id_instr = ins;
    id_pc = pc;
    id_rs1_data = a;
    id_rs2_data = b;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int unsigned k;
    ins = $urandom;
    k = $urandom_range(0, 12);
    case (k)
      0, 1:    ins[6:0] = 7'h33;
      2, 3:    ins[6:0] = 7'h13;
      4:       ins[6:0] = 7'h37;
      5:       ins[6:0] = 7'h17;
      6:       ins[6:0] = 7'h03;
      7:       ins[6:0] = 7'h23;
      8:       ins[6:0] = 7'h6F;
      9:       ins[6:0] = 7'h67;
      10:      ins[6:0] = 7'h63;
      11:      ins[6:0] = 7'h7F;
      default: ins[6:0] = 7'h73;
    endcase
    if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
      case ($urandom_range(0, 3))
        0, 2:    ins[31:25] = 7'h00;
        1:       ins[31:25] = 7'h20;
        default: ;
      endcase
    end
    if (ins[6:0] == 7'h63 && ins[14:13] == 2'b01) ins[14] = 1'b1;
    if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
    return ins;
  endfunction

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(32'h0000_0013, 32'h0, 32'h0, 32'h0);
    id_valid = 1'b0;
    tick();
    tick();
    check_all();
    check("rst_pc", ex_pc, RST_PC);
    check("rst_valid", 32'(ex_valid), 32'd0);
    rst = 1'b0;

    // add x3,x1,x2
    set_id(32'h0020_81B3, 32'h0000_1000, 32'd5, 32'd7);
    tick();
    check("add_alu", 32'(ex_alu_control), 32'h0);
    check("add_a", ex_op_a, 32'd5);
    check("add_b", ex_op_b, 32'd7);
    check("add_rd", 32'(ex_rd), 32'd3);
    check("add_rw", 32'(ex_reg_write), 32'd1);
    check_all();

    set_id(32'h4020_81B3, 32'h0000_1004, 32'd9, 32'd4);
    tick();
    check("sub_alu", 32'(ex_alu_control), 32'h1);
    check_all();
    set_id(32'h4033_5293, 32'h0000_1008, 32'hF000_0000, 32'd0);
    tick();
    check("srai_alu", 32'(ex_alu_control), 32'hB);
    check("srai_b", ex_op_b, 32'd3);
    check_all();
    set_id(32'hFFF0_0093, 32'h0000_100C, 32'd0, 32'd0);
    tick();
    check("addi_alu", 32'(ex_alu_control), 32'h0);
    check("addi_b", ex_op_b, 32'hFFFF_FFFF);
    check_all();
    set_id(32'h1234_5137, 32'h0000_1010, 32'hDEAD_BEEF, 32'd0);
    tick();
    check("lui_a", ex_op_a, 32'd0);
    check("lui_b", ex_op_b, 32'h1234_5000);
    check("lui_alu", 32'(ex_alu_control), 32'h0);
    check_all();
    // bltu x1,x2,0
    set_id(32'h0020_E063, 32'h0000_1014, 32'd1, 32'd2);
    tick();
    check("bltu_alu", 32'(ex_alu_control), 32'h6);
    check("bltu_br", 32'(ex_branch), 32'd1);
    check("bltu_rw", 32'(ex_reg_write), 32'd0);
    check_all();

    // Stall holds everything while the ID side keeps changing.
    set_id(32'h0020_81B3, 32'h0000_2000, 32'd11, 32'd22);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(rand_instr(), $urandom, $urandom, $urandom);
      tick();
      check("stall_a", ex_op_a, 32'd11);
      check("stall_b", ex_op_b, 32'd22);
      check("stall_rd", 32'(ex_rd), 32'd3);
      check("stall_pc", ex_pc, 32'h0000_2000);
      check("stall_valid", 32'(ex_valid), 32'd1);
    end
    flush = 1'b1;
    tick();
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_rw", 32'(ex_reg_write), 32'd0);
    check_all();
    flush = 1'b0; stall = 1'b0;

    set_id(32'h0020_81B3, 32'h0000_3000, 32'd1, 32'd2);
    tick();
    stall = 1'b1; rst = 1'b1;
    tick();
    check("rststall_pc", ex_pc, RST_PC);
    check("rststall_rw", 32'(ex_reg_write), 32'd0);
    check("rststall_valid", 32'(ex_valid), 32'd0);
    check_all();
    stall = 1'b0; rst = 1'b0;

    set_id(32'h0000_007F, 32'h0000_4000, 32'd1, 32'd2);
    tick();
    check("ill_flag", 32'(ex_illegal), 32'd1);
    check("ill_rw", 32'(ex_reg_write), 32'd0);
    check("ill_alu", 32'(ex_alu_control), 32'h0);
    check_all();
    set_id(32'h0010_0013, 32'h0000_4004, 32'd0, 32'd0);
    tick();
    check("x0_rw", 32'(ex_reg_write), 32'd0);
    check_all();
    set_id(32'h0020_81B3, 32'h0000_4008, 32'd1, 32'd2);
    id_valid = 1'b0;
    tick();
    check("nv_valid", 32'(ex_valid), 32'd0);
    check("nv_rw", 32'(ex_reg_write), 32'd0);
    check_all();

    for (int n = 0; n < 500; n++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 4) == 0);
      set_id(rand_instr(), $urandom & 32'hFFFF_FFFC, $urandom, $urandom);
      id_valid = ($urandom_range(0, 7) != 0);
      tick();
      check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
